fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, RV32I major opcodes and fetch FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its address while decode is stalled.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= NOP;
      pc    <= 32'h0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, skid buffer for decode stalls,
// and a drain state that swallows a stale response after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] IR,
  output logic [31:0] pc_out,
  output logic        ir_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         ir_valid_q, ir_valid_d;

  logic         skid_load, skid_unload, skid_clear;
  logic [31:0]  skid_data, skid_pc;
  logic         skid_valid;

  logic         handshake, out_free;
  logic [31:0]  redirect_target;

  // Gating with rst_n withdraws the request for the whole reset window.
  assign imem_req        = rst_n && (state_q != StHold);
  assign imem_addr       = pc_q;
  assign handshake       = imem_req && imem_ready;
  assign out_free        = !stall || !ir_valid_q;
  assign redirect_target = align_word(redirect_pc);

  assign IR       = ir_q;
  assign pc_out   = pc_out_q;
  assign ir_valid = ir_valid_q;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .load_pc   (pc_q),
    .data      (skid_data),
    .pc        (skid_pc),
    .valid     (skid_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    ir_d        = ir_q;
    pc_out_d    = pc_out_q;
    ir_valid_d  = ir_valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      ir_valid_d = 1'b0;
      ir_d       = NOP;
      skid_clear = 1'b1;
    end

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          if (handshake) begin
            pc_d = redirect_target;
          end else begin
            state_d  = StDrain;
            target_d = redirect_target;
          end
        end else if (handshake) begin
          pc_d = pc_q + 32'd4;
          if (out_free) begin
            ir_d       = imem_rdata;
            pc_out_d   = pc_q;
            ir_valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = StHold;
          end
        end else if (!stall) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = StFetch;
        end else if (!stall) begin
          ir_d        = skid_data;
          pc_out_d    = skid_pc;
          ir_valid_d  = skid_valid;
          skid_unload = 1'b1;
          state_d     = StFetch;
        end
      end
      StDrain: begin
        if (!stall) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP;
        end
        if (redirect) begin
          target_d = redirect_target;
        end
        // The response in flight belongs to the abandoned path; drop it.
        if (handshake) begin
          pc_d    = redirect ? redirect_target : target_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      ir_q       <= NOP;
      pc_out_q   <= 32'h0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple address-derived memory image.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] IR;
  logic [31:0] pc_out;
  logic        ir_valid;

  int vectors     = 0;
  int miscompares = 0;

  fetch_unit #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .IR          (IR),
    .pc_out      (pc_out),
    .ir_valid    (ir_valid)
  );

  // Word 0 holds addi x1,x0,5; every other word is 0xC000_0000 | address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (32'hC000_0000 | a);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no summary, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    tick();
    tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_ir", IR, NOP_W);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_skid", {31'b0, dut.u_skid.valid}, 32'd0);

    // Release reset with zero-wait memory
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, RESET_PC);
    tick();
    check("c1_ir", IR, 32'h0050_0093);
    check("c1_pc_out", pc_out, 32'h0);
    check("c1_valid", {31'b0, ir_valid}, 32'd1);
    check("c1_addr", imem_addr, 32'h4);
    tick();
    check("c2_ir", IR, 32'hC000_0004);
    check("c2_addr", imem_addr, 32'h8);

    // Stall with valid output: word at 8 goes to skid, HOLD for 3 cycles
    stall = 1'b1;
    tick();
    check("hold1_ir", IR, 32'hC000_0004);
    check("hold1_req", {31'b0, imem_req}, 32'd0);
    check("hold1_skid", {31'b0, dut.u_skid.valid}, 32'd1);
    tick();
    tick();
    check("hold3_ir", IR, 32'hC000_0004);
    check("hold3_pc_out", pc_out, 32'h4);
    check("hold3_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    check("unhold_ir", IR, 32'hC000_0008);
    check("unhold_pc_out", pc_out, 32'h8);
    check("unhold_req", {31'b0, imem_req}, 32'd1);
    check("unhold_addr", imem_addr, 32'hC);

    // Consumed with no new data -> bubble
    imem_ready = 1'b0;
    tick();
    check("bubble_valid", {31'b0, ir_valid}, 32'd0);
    check("bubble_ir", IR, NOP_W);

    // Stall while empty still loads
    stall      = 1'b1;
    imem_ready = 1'b1;
    tick();
    check("fill_ir", IR, 32'hC000_000C);
    check("fill_pc_out", pc_out, 32'hC);
    check("fill_valid", {31'b0, ir_valid}, 32'd1);

    // 2-wait memory at 0x10, redirect to 0x100 one cycle after request
    stall      = 1'b0;
    imem_ready = 1'b0;
    tick();
    check("w1_addr", imem_addr, 32'h10);
    check("w1_valid", {31'b0, ir_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect   = 1'b0;
    imem_ready = 1'b1;
    #1;
    check("drain_addr", imem_addr, 32'h10);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_valid", {31'b0, ir_valid}, 32'd0);
    imem_ready = 1'b0;
    tick();
    check("drain2_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    check("post_drain_addr", imem_addr, 32'h100);
    check("post_drain_valid", {31'b0, ir_valid}, 32'd0);
    check("post_drain_ir", IR, NOP_W);

    // Misaligned redirect with handshake in same cycle
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    check("align_addr", imem_addr, 32'h100);
    check("align_valid", {31'b0, ir_valid}, 32'd0);
    redirect = 1'b0;
    tick();
    check("t100_ir", IR, 32'hC000_0100);
    check("t100_pc_out", pc_out, 32'h100);

    // Fill skid, then redirect + stall together
    stall = 1'b1;
    tick();
    check("skid_full", {31'b0, dut.u_skid.valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    check("rs_valid", {31'b0, ir_valid}, 32'd0);
    check("rs_ir", IR, NOP_W);
    check("rs_skid", {31'b0, dut.u_skid.valid}, 32'd0);
    check("rs_addr", imem_addr, 32'h200);
    check("rs_req", {31'b0, imem_req}, 32'd1);

    // PC wraps modulo 2^32
    stall       = 1'b0;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check("wrap_ir", IR, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Redirect during DRAIN replaces saved target
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400;
    tick();
    check("d2_addr", imem_addr, 32'h0);
    redirect   = 1'b0;
    imem_ready = 1'b1;
    tick();
    check("d2_target", imem_addr, 32'h400);

    // Reset while draining
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    redirect = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("rd_req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rd_addr", imem_addr, RESET_PC);
    check("rd_valid", {31'b0, ir_valid}, 32'd0);
    tick();
    check("rd_addr2", imem_addr, RESET_PC);
    check("rd_req2", {31'b0, imem_req}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
